// File: rtl/maze_pkg.sv
// Shared types and grid-index helpers for the maze game blocks.
package maze_pkg;

   typedef enum logic [2:0] {
      NONE  = 3'd0,
      UP    = 3'd1,
      DOWN  = 3'd2,
      LEFT  = 3'd3,
      RIGHT = 3'd4
   } dir_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      HOLD = 2'd2
   } move_state_t;

   // Direction buttons sampled together each cycle.
   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
   } btn_t;

   function automatic int unsigned idx_row(input int unsigned idx, input int unsigned cols);
      return idx / cols;
   endfunction

   function automatic int unsigned idx_col(input int unsigned idx, input int unsigned cols);
      return idx % cols;
   endfunction

   function automatic int unsigned rc_to_idx(input int unsigned row, input int unsigned col,
                                             input int unsigned cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/player_move_ctrl_if.sv
// Button/load/maze inputs and position/pulse outputs of the player movement controller.
interface player_move_ctrl_if #(
   parameter int unsigned COLS  = 10,
   parameter int unsigned ROWS  = 10,
   parameter int unsigned POS_W = 8
);
   localparam int unsigned CELLS = COLS * ROWS;

   logic [CELLS-1:0] maze;
   logic             btnU;
   logic             btnD;
   logic             btnL;
   logic             btnR;
   logic             load;
   logic [POS_W-1:0] load_pos;
   logic [POS_W-1:0] pos_out;
   logic             move_ok;
   logic             bump;
   logic             at_goal;

   modport master (
      output maze, btnU, btnD, btnL, btnR, load, load_pos,
      input  pos_out, move_ok, bump, at_goal
   );

   modport slave (
      input  maze, btnU, btnD, btnL, btnR, load, load_pos,
      output pos_out, move_ok, bump, at_goal
   );

endinterface

// File: rtl/player_step_calc.sv
// Combinational single-cell move evaluation: grid boundary, optional wrap and wall check.
// Macro PLAYER_WRAP_EN: off-grid moves wrap to the opposite edge instead of bumping.
module player_step_calc
   import maze_pkg::*;
#(
   parameter int unsigned COLS  = 10,
   parameter int unsigned ROWS  = 10,
   parameter int unsigned POS_W = 8
) (
   input  logic [POS_W-1:0]     pos,
   input  dir_t                 dir,
   input  logic [COLS*ROWS-1:0] maze,
   output logic [POS_W-1:0]     target,
   output logic                 blocked
);

   localparam int unsigned CELLS = COLS * ROWS;
`ifdef PLAYER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   int unsigned      row;
   int unsigned      col;
   int unsigned      t_row;
   int unsigned      t_col;
   logic             off_grid;
   logic [POS_W-1:0] wrapped;
   logic [CELLS-1:0] cell_sel;

   // Off-grid targets are pre-wrapped; the no-wrap build then discards them as a bump.
   always_comb begin
      row      = idx_row(32'(pos), COLS);
      col      = idx_col(32'(pos), COLS);
      t_row    = row;
      t_col    = col;
      off_grid = 1'b0;
      case (dir)
         UP: begin
            if (row == 0) begin
               off_grid = 1'b1;
               t_row    = ROWS - 1;
            end else begin
               t_row = row - 1;
            end
         end
         DOWN: begin
            if (row == ROWS - 1) begin
               off_grid = 1'b1;
               t_row    = 0;
            end else begin
               t_row = row + 1;
            end
         end
         LEFT: begin
            if (col == 0) begin
               off_grid = 1'b1;
               t_col    = COLS - 1;
            end else begin
               t_col = col - 1;
            end
         end
         RIGHT: begin
            if (col == COLS - 1) begin
               off_grid = 1'b1;
               t_col    = 0;
            end else begin
               t_col = col + 1;
            end
         end
         default: ;
      endcase

      wrapped  = POS_W'(rc_to_idx(t_row, t_col, COLS));
      cell_sel = CELLS'(1) << wrapped;

      if (off_grid && !WRAP) begin
         target  = pos;
         blocked = 1'b1;
      end else begin
         target  = wrapped;
         blocked = |(maze & cell_sel);
      end
   end

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement controller: button edge detect, step/hold-repeat FSM, position register.
// Macro PLAYER_WRAP_EN (evaluated in player_step_calc) makes off-grid moves wrap around.
module player_move_ctrl
   import maze_pkg::*;
#(
   parameter int unsigned COLS        = 10,
   parameter int unsigned ROWS        = 10,
   parameter int unsigned POS_W       = 8,
   parameter int unsigned START_POS   = 0,
   parameter int unsigned GOAL_POS    = COLS * ROWS - 1,
   parameter int unsigned HOLD_CYCLES = 12_500_000
) (
   input  logic              clk,
   input  logic              rst,
   player_move_ctrl_if.slave bus
);

   localparam int unsigned      CELLS    = COLS * ROWS;
   localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   move_state_t      state_q;
   move_state_t      state_d;
   dir_t             dir_q;
   dir_t             dir_d;
   dir_t             sel_dir;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [POS_W-1:0] pos_q;
   logic [POS_W-1:0] pos_d;
   logic [POS_W-1:0] target;
   logic             move_ok_q;
   logic             move_ok_d;
   logic             bump_q;
   logic             bump_d;
   btn_t             btn_now;
   btn_t             btn_prev_q;
   logic             any_rise;
   logic             held;
   logic             load_ok;
   logic             blocked;

   assign btn_now  = {bus.btnU, bus.btnD, bus.btnL, bus.btnR};
   assign any_rise = |(btn_now & ~btn_prev_q);
   assign load_ok  = bus.load && (32'(bus.load_pos) < CELLS);

   // Fixed priority U > D > L > R among the buttons currently high.
   always_comb begin
      sel_dir = NONE;
      if (btn_now.up) begin
         sel_dir = UP;
      end else if (btn_now.down) begin
         sel_dir = DOWN;
      end else if (btn_now.left) begin
         sel_dir = LEFT;
      end else if (btn_now.right) begin
         sel_dir = RIGHT;
      end
   end

   always_comb begin
      held = 1'b0;
      case (dir_q)
         UP:      held = btn_now.up;
         DOWN:    held = btn_now.down;
         LEFT:    held = btn_now.left;
         RIGHT:   held = btn_now.right;
         default: held = 1'b0;
      endcase
   end

   player_step_calc #(
      .COLS  (COLS),
      .ROWS  (ROWS),
      .POS_W (POS_W)
   ) u_step_calc (
      .pos     (pos_q),
      .dir     (dir_q),
      .maze    (bus.maze),
      .target  (target),
      .blocked (blocked)
   );

   // A valid load overrides whatever the FSM would do this cycle.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      pos_d     = pos_q;
      move_ok_d = 1'b0;
      bump_d    = 1'b0;
      if (load_ok) begin
         pos_d   = bus.load_pos;
         state_d = IDLE;
         dir_d   = NONE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_rise) begin
                  state_d = STEP;
                  dir_d   = sel_dir;
               end
            end
            STEP: begin
               if (blocked) begin
                  bump_d = 1'b1;
               end else begin
                  pos_d     = target;
                  move_ok_d = 1'b1;
               end
               state_d = HOLD;
               cnt_d   = '0;
            end
            HOLD: begin
               if (!held) begin
                  state_d = IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = STEP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         dir_q      <= NONE;
         cnt_q      <= '0;
         pos_q      <= POS_W'(START_POS);
         move_ok_q  <= 1'b0;
         bump_q     <= 1'b0;
         btn_prev_q <= '0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         cnt_q      <= cnt_d;
         pos_q      <= pos_d;
         move_ok_q  <= move_ok_d;
         bump_q     <= bump_d;
         btn_prev_q <= btn_now;
      end
   end

   assign bus.pos_out = pos_q;
   assign bus.move_ok = move_ok_q;
   assign bus.bump    = bump_q;
   assign bus.at_goal = (pos_q == POS_W'(GOAL_POS));

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: directed move table, hold/load/reset sequences, random vs model.
module tb_player_move_ctrl;

   localparam int COLS  = 10;
   localparam int ROWS  = 10;
   localparam int POS_W = 8;
   localparam int CELLS = COLS * ROWS;
   localparam int GOAL  = CELLS - 1;
   localparam int HOLD  = 4;
`ifdef PLAYER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   typedef struct {
      int         start;
      logic [3:0] btns;     // {U, D, L, R}
      int         wall;     // -1 for an empty maze
      int         exp_pos;
      bit         exp_move;
      bit         exp_bump;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   int         m_pos;
   int         m_dir;   // -1 idle, else button index 3=U 2=D 1=L 0=R
   int         m_cd;    // edges until the next move attempt while active
   logic [3:0] m_prev;
   bit         m_move;
   bit         m_bump;

   player_move_ctrl_if #(.COLS(COLS), .ROWS(ROWS), .POS_W(POS_W)) bus ();

   player_move_ctrl #(
      .COLS        (COLS),
      .ROWS        (ROWS),
      .POS_W       (POS_W),
      .START_POS   (0),
      .GOAL_POS    (GOAL),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic vec_t mk(input int start, input logic [3:0] btns, input int wall,
                               input int ep, input bit em, input bit eb);
      vec_t v;
      v.start = start; v.btns = btns; v.wall = wall;
      v.exp_pos = ep; v.exp_move = em; v.exp_bump = eb;
      return v;
   endfunction

   function automatic logic [CELLS-1:0] rand_maze();
      logic [CELLS-1:0] m;
      for (int i = 0; i < CELLS; i++) m[i] = ($urandom_range(0, 6) == 0);
      return m;
   endfunction

   // Move attempt in row/column coordinates from the latched direction.
   task automatic model_try_move(input logic [CELLS-1:0] mz);
      int r, c, nr, nc;
      bit off;
      r = m_pos / COLS; c = m_pos % COLS; nr = r; nc = c;
      case (m_dir)
         3:       nr = r - 1;
         2:       nr = r + 1;
         1:       nc = c - 1;
         default: nc = c + 1;
      endcase
      off = (nr < 0) || (nr >= ROWS) || (nc < 0) || (nc >= COLS);
      if (off && !WRAP) begin
         m_bump = 1'b1;
      end else begin
         nr = (nr + ROWS) % ROWS;
         nc = (nc + COLS) % COLS;
         if (mz[nr * COLS + nc]) m_bump = 1'b1;
         else begin
            m_pos  = nr * COLS + nc;
            m_move = 1'b1;
         end
      end
   endtask

   // What one clock edge does, given the inputs present at that edge.
   task automatic model_edge(input logic r, input logic [3:0] b, input logic ld,
                             input int lp, input logic [CELLS-1:0] mz);
      logic [3:0] rise;
      rise   = b & ~m_prev;
      m_move = 1'b0;
      m_bump = 1'b0;
      if (r) begin
         m_pos = 0; m_dir = -1; m_cd = 0; m_prev = '0;
         return;
      end
      m_prev = b;
      if (ld && lp < CELLS) begin
         m_pos = lp; m_dir = -1;
      end else if (m_dir < 0) begin
         if (rise != 0) begin
            m_dir = b[3] ? 3 : b[2] ? 2 : b[1] ? 1 : 0;
            m_cd  = 1;
         end
      end else if (m_cd == 1) begin
         model_try_move(mz);
         m_cd = HOLD + 1;
      end else if (!b[m_dir]) begin
         m_dir = -1;
      end else begin
         m_cd--;
      end
   endtask

   task automatic set_btns(input logic [3:0] b);
      {bus.btnU, bus.btnD, bus.btnL, bus.btnR} = b;
   endtask

   task automatic do_load(input int p);
      bus.load = 1'b1; bus.load_pos = POS_W'(p);
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   initial begin
      vec_t             vecs[14];
      logic [3:0]       btn;
      logic             r_rst, r_load;
      int               r_lp, exp_p;
      logic [CELLS-1:0] r_maze;

      vecs[0]  = mk(0,  4'b0001, -1, 1, 1, 0);
      vecs[1]  = mk(0,  4'b1000, -1, WRAP ? 90 : 0, WRAP, !WRAP);
      vecs[2]  = mk(1,  4'b0100, 11, 1, 0, 1);
      vecs[3]  = mk(1,  4'b0100, -1, 11, 1, 0);
      vecs[4]  = mk(55, 4'b1010, -1, 45, 1, 0);
      vecs[5]  = mk(9,  4'b0001, -1, WRAP ? 0 : 9, WRAP, !WRAP);
      vecs[6]  = mk(90, 4'b0010, -1, WRAP ? 99 : 90, WRAP, !WRAP);
      vecs[7]  = mk(95, 4'b0100, -1, WRAP ? 5 : 95, WRAP, !WRAP);
      vecs[8]  = mk(0,  4'b0010, 9, 0, 0, 1);
      vecs[9]  = mk(50, 4'b0001, 51, 50, 0, 1);
      vecs[10] = mk(55, 4'b0101, -1, 65, 1, 0);
      vecs[11] = mk(55, 4'b0011, -1, 54, 1, 0);
      vecs[12] = mk(99, 4'b1000, -1, 89, 1, 0);
      vecs[13] = mk(19, 4'b0001, 20, WRAP ? 10 : 19, WRAP, !WRAP);

      rst = 1'b1; bus.maze = '0; set_btns(4'b0000); bus.load = 1'b0; bus.load_pos = '0;
      @(negedge clk);
      chk("reset_pos", 32'(bus.pos_out), 0);
      chk("reset_move_ok", 32'(bus.move_ok), 0);
      chk("reset_bump", 32'(bus.bump), 0);
      chk("reset_at_goal", 32'(bus.at_goal), 0);
      rst = 1'b0;

      // Single press from a loaded position, checked before, at and after the move edge.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         bus.maze = '0;
         if (vecs[i].wall >= 0) bus.maze[vecs[i].wall] = 1'b1;
         do_load(vecs[i].start);
         chk("vec_load_pos", 32'(bus.pos_out), 32'(vecs[i].start));
         set_btns(vecs[i].btns);
         @(negedge clk);
         set_btns(4'b0000);
         chk("vec_early_move_ok", 32'(bus.move_ok), 0);
         chk("vec_early_bump", 32'(bus.bump), 0);
         @(negedge clk);
         chk("vec_pos", 32'(bus.pos_out), 32'(vecs[i].exp_pos));
         chk("vec_move_ok", 32'(bus.move_ok), 32'(vecs[i].exp_move));
         chk("vec_bump", 32'(bus.bump), 32'(vecs[i].exp_bump));
         @(negedge clk);
         chk("vec_pulse_end", 32'({bus.move_ok, bus.bump}), 0);
      end

      // Hold R for 20 edges: moves at edges 1, 6, 11, 16, none after release.
      bus.maze = '0;
      do_load(0);
      set_btns(4'b0001);
      for (int j = 0; j < 26; j++) begin
         @(negedge clk);
         exp_p = (j >= 16) ? 4 : (j >= 11) ? 3 : (j >= 6) ? 2 : (j >= 1) ? 1 : 0;
         chk("hold_pos", 32'(bus.pos_out), 32'(exp_p));
         chk("hold_move_ok", 32'(bus.move_ok), 32'(j == 1 || j == 6 || j == 11 || j == 16));
         if (j == 19) set_btns(4'b0000);
      end

      // Load: out of range ignored, in range accepted, beats a pending STEP.
      do_load(200);
      chk("load_oor_pos", 32'(bus.pos_out), 4);
      chk("load_oor_pulse", 32'({bus.move_ok, bus.bump}), 0);
      do_load(99);
      chk("load_99_pos", 32'(bus.pos_out), 99);
      chk("load_99_goal", 32'(bus.at_goal), 1);
      do_load(0);
      set_btns(4'b0001);
      @(negedge clk);
      set_btns(4'b0000);
      do_load(30);
      chk("load_in_step_pos", 32'(bus.pos_out), 30);
      chk("load_in_step_pulse", 32'({bus.move_ok, bus.bump}), 0);
      @(negedge clk);
      chk("load_in_step_after", 32'(bus.pos_out), 30);

      // Reset during HOLD aborts, and reset beats load.
      do_load(0);
      set_btns(4'b0001);
      repeat (3) @(negedge clk);
      chk("pre_reset_pos", 32'(bus.pos_out), 1);
      rst = 1'b1; set_btns(4'b0000); bus.load = 1'b1; bus.load_pos = 8'd50;
      @(negedge clk);
      rst = 1'b0; bus.load = 1'b0;
      chk("hold_reset_pos", 32'(bus.pos_out), 0);
      chk("hold_reset_pulse", 32'({bus.move_ok, bus.bump}), 0);
      repeat (6) @(negedge clk);
      chk("post_reset_pos", 32'(bus.pos_out), 0);

      // Random stimulus against the reference model.
      btn = '0; r_maze = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c > 0) begin
            chk("rnd_pos", 32'(bus.pos_out), 32'(m_pos));
            chk("rnd_move_ok", 32'(bus.move_ok), 32'(m_move));
            chk("rnd_bump", 32'(bus.bump), 32'(m_bump));
            chk("rnd_at_goal", 32'(bus.at_goal), 32'(m_pos == GOAL));
         end
         r_rst = (c == 0) || ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 5) == 0) begin
            int k;
            k = int'($urandom_range(0, 3));
            btn[k] = ~btn[k];
         end
         r_load = ($urandom_range(0, 49) == 0);
         r_lp   = int'($urandom_range(0, 255));
         if ($urandom_range(0, 99) == 0) r_maze = rand_maze();
         rst = r_rst; set_btns(btn); bus.load = r_load; bus.load_pos = POS_W'(r_lp);
         bus.maze = r_maze;
         model_edge(r_rst, btn, r_load, r_lp, r_maze);
      end
      @(negedge clk);
      chk("rnd_final_pos", 32'(bus.pos_out), 32'(m_pos));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Parametrised player-movement controller for the maze game. It converts the four direction buttons into single-cell moves on a COLS×ROWS grid, with wall collision, boundary handling and hold-to-repeat. It replaces the fixed 10×10 combinational position logic, sits between the button front-end and the VGA renderer and win logic, and owns the authoritative player position register.

## Interface
- COLS, default 10, grid width in cells.
- ROWS, default 10, grid height in cells.
- POS_W, default 8, position index width; must be ≥ clog2(COLS*ROWS).
- START_POS, default 0, position loaded on reset.
- GOAL_POS, default COLS*ROWS-1, cell that asserts at_goal.
- HOLD_CYCLES, default 12_500_000, clk cycles between auto-repeat moves while a button is held; ≥ 2.
- clk  in  1  system clock; the block uses this single clock.
- rst  in  1  reset; synchronous, active-high.
- maze  in  COLS*ROWS  wall map; bit i = 1 means cell i is a wall.
- btnU, btnD, btnL, btnR  in  1 each  debounced, synchronised direction buttons; high = pressed.
- load  in  1  one-cycle request to force the position to load_pos.
- load_pos  in  POS_W  position for load.
- pos_out  out  POS_W  current index: row*COLS + col, row 0 at the top.
- move_ok  out  1  one-cycle pulse on a successful move.
- bump  out  1  one-cycle pulse on a blocked attempt.
- at_goal  out  1  level; high while pos_out == GOAL_POS.

## Operation
- Reset values: pos_out = START_POS; move_ok = 0; bump = 0; FSM = IDLE; hold counter = 0; all button history = 0.
- Active direction selection: when more than one button is high, priority is U > D > L > R.
- Move targets:
  - U: row-1.
  - D: row+1.
  - L: col-1.
  - R: col+1.
- FSM states:
  - IDLE: a rising edge on any button (high now, low last cycle) latches the active direction and goes to STEP.
  - STEP: evaluate the target for exactly one cycle. If the target is off-grid or is a wall: bump pulses and pos_out is unchanged. Otherwise pos_out ← target and move_ok pulses. Then go to HOLD with the counter cleared.
  - HOLD: the counter increments each cycle while the latched button stays high. At HOLD_CYCLES-1, go to STEP. If the latched button goes low, go to IDLE. Other buttons are ignored in HOLD.
- Boundaries: row 0 going U, row ROWS-1 going D, col 0 going L and col COLS-1 going R are off-grid, giving bump with no change. No row carry: col COLS-1 going R never reaches the next row.
- Walls: the maze is sampled in the STEP cycle only. A maze change at any other time has no effect on a pending move.
- load:
  - load has priority over every FSM action in the same cycle.
  - If load_pos < COLS*ROWS: pos_out ← load_pos and FSM → IDLE, even if the cell is a wall.
  - If load_pos ≥ COLS*ROWS: load is ignored entirely.
  - No move_ok or bump is generated.
- rst beats load. Reset mid-HOLD or mid-STEP aborts the move; outputs take their reset values on that edge.
- at_goal is combinational from the pos_out register.

## Timing
- Edge N: the first sampled high of a button in IDLE → state STEP.
- Edge N+1: pos_out updated and move_ok or bump high, for the cycle following N+1 only.
- Press-to-move latency: 2 edges.
- Repeat period while held: exactly HOLD_CYCLES+1 cycles between successive STEP cycles (HOLD_CYCLES in HOLD plus 1 in STEP).
- A button released and re-pressed within the same HOLD window restarts from IDLE on the next rising edge.

## Configuration
- PLAYER_WRAP_EN defined: off-grid moves wrap to the opposite edge of the same row or column (e.g. col COLS-1 going R → col 0). The wrapped cell is still wall-checked; bump occurs only on a wall.
- PLAYER_WRAP_EN undefined: off-grid moves give bump, as above.

## Structure
- Shared package maze_pkg:
  - dir_t enum: NONE, UP, DOWN, LEFT, RIGHT.
  - FSM state enum.
  - Helper functions idx_row, idx_col and rc_to_idx, parametrised by COLS.
- One sub-module, player_step_calc, is combinational. Inputs: pos, dir, maze. Outputs: target and blocked. It contains the boundary, wrap and wall logic, so it can be unit-tested alone.
- Top level holds the FSM, edge detect, hold counter and position register.

## Test plan
- Default 10×10, empty maze, pos 0, press btnR one cycle → pos_out = 1 two edges after the press, one move_ok pulse, bump = 0.
- pos 0, press btnU → bump pulse, pos_out stays 0. With PLAYER_WRAP_EN: pos_out = 90.
- maze bit 11 = 1, pos 1, press btnD → bump, pos stays 1. Clear bit 11, press again → pos_out = 11.
- HOLD_CYCLES=4, pos 0, hold btnR for 20 cycles → pos_out steps 1, 2, 3, 4 at 5-cycle spacing. Release → no further moves.
- btnU and btnL rise together at pos 55 → pos_out = 45 (U priority).
- load = 1 with load_pos = 200 → ignored. load_pos = 99 → pos_out = 99 and at_goal = 1. Assert rst during HOLD → pos_out = 0 next edge, no pulses.
